// File: rtl/router_pkt_tx_if.sv
// router_pkt_tx_if: host stream, router link and status signals of the packet transmitter
interface router_pkt_tx_if;
  logic       start;
  logic [1:0] dest;
  logic [5:0] len;
  logic       corrupt_parity;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       busy;
  logic       err;
  logic       pkt_valid;
  logic [7:0] data_out;
  logic       tx_idle;
  logic       cfg_err;
  logic       done;
  logic       pkt_err;
  logic [7:0] parity_out;
  modport master (
    output start, dest, len, corrupt_parity, in_data, in_valid, busy, err,
    input  in_ready, pkt_valid, data_out, tx_idle, cfg_err, done, pkt_err, parity_out
  );
  modport slave (
    input  start, dest, len, corrupt_parity, in_data, in_valid, busy, err,
    output in_ready, pkt_valid, data_out, tx_idle, cfg_err, done, pkt_err, parity_out
  );
endinterface

// File: rtl/router_pkt_tx.sv
// router_pkt_tx: buffers a payload, then sends header/payload/parity to the router and captures err
module router_pkt_tx #(
  parameter int MAXLEN   = 63,
  parameter int ERR_WAIT = 3
) (
  input logic           clk,
  input logic           resetn,
  router_pkt_tx_if.slave bus
);
  typedef enum logic [2:0] {IDLE, LOAD, HEADER, PAYLOAD, PARITY, CHECK} state_t;
  state_t     state_q, state_d;
  logic [1:0] dest_q, dest_d;
  logic [5:0] len_q, len_d, wr_cnt_q, wr_cnt_d, rd_idx_q, rd_idx_d;
  logic       corrupt_q, corrupt_d, pkt_err_q, pkt_err_d, cfg_err_q, cfg_err_d, done_q, done_d, we;
  logic [7:0] par_q, par_d, parity_out_q, parity_out_d, wait_cnt_q, wait_cnt_d;
  logic [7:0] mem_q [MAXLEN];
  logic [7:0] header, par_tx;
  assign header = {len_q, dest_q};
  assign par_tx = par_q ^ {8{corrupt_q}};
  assign bus.in_ready   = state_q == LOAD;
  assign bus.pkt_valid  = state_q == HEADER || state_q == PAYLOAD;
  assign bus.tx_idle    = state_q == IDLE;
  assign bus.cfg_err    = cfg_err_q;
  assign bus.done       = done_q;
  assign bus.pkt_err    = pkt_err_q;
  assign bus.parity_out = parity_out_q;
  assign bus.data_out   = state_q == HEADER  ? header :
                          state_q == PAYLOAD ? mem_q[rd_idx_q] :
                          (state_q == PARITY || state_q == CHECK) ? par_tx : 8'h00;
  always_comb begin
    state_d      = state_q;
    dest_d       = dest_q;
    len_d        = len_q;
    corrupt_d    = corrupt_q;
    par_d        = par_q;
    wr_cnt_d     = wr_cnt_q;
    rd_idx_d     = rd_idx_q;
    wait_cnt_d   = wait_cnt_q;
    pkt_err_d    = pkt_err_q;
    parity_out_d = parity_out_q;
    cfg_err_d    = 1'b0;
    done_d       = 1'b0;
    we           = 1'b0;
    case (state_q)
      IDLE: if (bus.start) begin
        if (bus.dest != 2'd3 && bus.len != 6'd0) begin
          dest_d    = bus.dest;
          len_d     = bus.len;
          corrupt_d = bus.corrupt_parity;
          par_d     = {bus.len, bus.dest};
          pkt_err_d = 1'b0;
          wr_cnt_d  = 6'd0;
          state_d   = LOAD;
        end else cfg_err_d = 1'b1;
      end
      LOAD: if (bus.in_valid) begin
        we       = 1'b1;
        par_d    = par_q ^ bus.in_data;
        wr_cnt_d = wr_cnt_q + 6'd1;
        state_d  = wr_cnt_q == len_q - 6'd1 ? HEADER : LOAD;
      end
      HEADER: if (!bus.busy) begin
        rd_idx_d = 6'd0;
        state_d  = PAYLOAD;
      end
      PAYLOAD: if (!bus.busy) begin
        rd_idx_d = rd_idx_q + 6'd1;
        state_d  = rd_idx_q == len_q - 6'd1 ? PARITY : PAYLOAD;
      end
      PARITY: if (!bus.busy) begin
        parity_out_d = par_q;
        wait_cnt_d   = 8'd0;
        state_d      = CHECK;
      end
      CHECK: begin
        pkt_err_d  = pkt_err_q | bus.err;
        wait_cnt_d = wait_cnt_q + 8'd1;
        if (wait_cnt_q == 8'(ERR_WAIT - 1)) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= IDLE;
      dest_q       <= 2'd0;
      len_q        <= 6'd0;
      corrupt_q    <= 1'b0;
      par_q        <= 8'h00;
      wr_cnt_q     <= 6'd0;
      rd_idx_q     <= 6'd0;
      wait_cnt_q   <= 8'd0;
      pkt_err_q    <= 1'b0;
      parity_out_q <= 8'h00;
      cfg_err_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      dest_q       <= dest_d;
      len_q        <= len_d;
      corrupt_q    <= corrupt_d;
      par_q        <= par_d;
      wr_cnt_q     <= wr_cnt_d;
      rd_idx_q     <= rd_idx_d;
      wait_cnt_q   <= wait_cnt_d;
      pkt_err_q    <= pkt_err_d;
      parity_out_q <= parity_out_d;
      cfg_err_q    <= cfg_err_d;
      done_q       <= done_d;
    end
  end
  // Payload storage needs no reset: a new packet always rewrites every byte it reads back.
  always_ff @(posedge clk) begin
    if (resetn && we) mem_q[wr_cnt_q] <= bus.in_data;
  end
endmodule

// File: doc/router_pkt_tx.md
# router_pkt_tx

Source-side packet transmitter for the 1x3 router input port. It buffers a complete payload from a host stream, then drives a router packet onto `pkt_valid`/`data_out`: header, payload, then parity. It honours the router's `busy` back-pressure and captures the router's `err` verdict after the parity byte. It sits in front of the router's input FSM, as the sender for that receiver, and doubles as the stimulus engine for router-level benches.

## Interface
- `MAXLEN`, 63: payload buffer depth in bytes. Payload length field is 6 bits; `MAXLEN` must be ≤ 63.
- `ERR_WAIT`, 3: number of cycles `err` is sampled after the parity byte is taken.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `resetn`  in  1  synchronous, active-low reset.
- `start`  in  1  packet request; accepted only in IDLE.
- `dest`  in  2  destination port 0..2; 3 is illegal.
- `len`  in  6  payload byte count 1..63; 0 is illegal.
- `corrupt_parity`  in  1  sampled with `start`; inverts the transmitted parity byte (error injection).
- `in_data`  in  8  payload byte from host.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  transmitter accepts `in_data`.
- `busy`  in  1  router back-pressure.
- `err`  in  1  router parity-error flag.
- `pkt_valid`  out  1  router packet-valid.
- `data_out`  out  8  router data bus.
- `tx_idle`  out  1  high in IDLE.
- `cfg_err`  out  1  1-cycle pulse when a `start` is rejected.
- `done`  out  1  1-cycle pulse at packet completion.
- `pkt_err`  out  1  `err` seen for the last packet; cleared on next accepted `start`.
- `parity_out`  out  8  parity byte computed for the last packet (uncorrupted).

## Operation
- Header byte = {len[5:0], dest[1:0]}. Parity = XOR of header and all payload bytes.
- States:
  - IDLE
  - LOAD
  - HEADER
  - PAYLOAD
  - PARITY
  - CHECK
- IDLE:
  - `tx_idle`=1.
  - `start` with dest≠3 and len≠0: latch dest, len and corrupt flag; parity reg ← header; `pkt_err`←0; wr_cnt←0; go to LOAD.
  - `start` with dest=3 or len=0: `cfg_err` pulses the next cycle; stay in IDLE.
- LOAD:
  - `in_ready`=1.
  - Each cycle with `in_valid`: buf[wr_cnt]←`in_data`, parity ^= `in_data`, wr_cnt++.
  - The write with wr_cnt==len-1 moves to HEADER. Gaps on `in_valid` are allowed.
- HEADER: `pkt_valid`=1, `data_out`=header. A byte is taken at a rising edge where `busy`=0; on that edge go to PAYLOAD with rd_idx←0.
- PAYLOAD:
  - `pkt_valid`=1, `data_out`=buf[rd_idx].
  - While `busy`=1, hold byte and index.
  - Edge with `busy`=0: rd_idx++. If rd_idx==len-1, go to PARITY.
  - `pkt_valid` never drops mid-payload; the full buffer guarantees this.
- PARITY:
  - `pkt_valid`=0, `data_out`=parity, or ~parity if the corrupt flag is set.
  - Held until an edge with `busy`=0; then `parity_out`←parity (uncorrupted), wait_cnt←0, go to CHECK.
- CHECK:
  - `data_out` holds the parity byte; `err` is ORed into `pkt_err` each cycle.
  - After `ERR_WAIT` cycles: `done` pulses and the state returns to IDLE.
- Back-to-back: a `start` in the cycle after `done` is accepted.

## Timing
- Reset values: `pkt_valid`=0, `data_out`=0, `in_ready`=0, `tx_idle`=1, `cfg_err`=0, `done`=0, `pkt_err`=0, `parity_out`=0. Internal counters and parity reg are 0.
- Outputs are decoded from registered state and registers only; there is no combinational path from `busy` or `in_valid` to outputs.
- Latency:
  - `start` accepted at edge N → `in_ready`=1 from N+1.
  - Last payload write at edge M → header on `data_out` from M+1.
- Minimum packet with no stalls: 1 header + len payload + 1 parity cycle, then `ERR_WAIT` cycles, then `done`.
- `resetn`=0 in any state: IDLE at the next edge, `pkt_valid`=0, buffer content discarded, `pkt_err` cleared.
- `busy` toggling every cycle: each byte advances only on `busy`=0 edges; no byte is skipped or duplicated.
- `start` outside IDLE is ignored, with no `cfg_err`.

## Test plan
- Nominal packet: dest=1, len=3, payload 0x11,0x22,0x33, `busy`=0 → `data_out` 0x0D, 0x11, 0x22, 0x33 with `pkt_valid`=1, then 0x0D with `pkt_valid`=0. `parity_out`=0x0D, `done` pulses, `pkt_err`=0.
- Stall: same packet, `busy`=1 for 4 cycles after the header is taken → `data_out` holds 0x11 for those cycles, `pkt_valid` stays 1, sequence otherwise unchanged.
- Illegal request: `start` with dest=3, then with len=0 → `cfg_err` pulses each time, `tx_idle` stays 1, `pkt_valid` never asserts.
- Parity injection: dest=0, len=1, payload 0xA5, `corrupt_parity`=1; router model drives `err`=1 two cycles after parity → parity byte on bus 0x5E (~0xA1), `parity_out`=0xA1, `pkt_err`=1 at `done`.
- Max length: len=63, payload 0..62 with random `in_valid` gaps → header 0xFC, 63 contiguous payload cycles (no `busy`), parity = 0xFC ^ XOR(0..62).
- Reset mid-PAYLOAD after 5 bytes → `pkt_valid`=0 next cycle, `tx_idle`=1; a fresh packet then transmits correctly.
